// File: rtl/light_pkg.sv
// Shared light-state codes for the tail-light controller.
// Used by the input encoder and the lamp driver.
package light_pkg;

    typedef logic [1:0] light_code_t;

    localparam light_code_t CODE_NONE  = 2'b00;
    localparam light_code_t CODE_BRAKE = 2'b01;
    localparam light_code_t CODE_TURN  = 2'b10;
    localparam light_code_t CODE_BOTH  = 2'b11;

    function automatic light_code_t encode(
        input logic turn_s,
        input logic brake_s
    );
        return {turn_s, brake_s};
    endfunction

endpackage

// File: rtl/signal_encoder_if.sv
// Switch inputs and encoded light-state outputs of the encoder.
// The master drives the raw switches; the slave returns the code.
interface signal_encoder_if;
    import light_pkg::*;

    logic        brake;
    logic        turn;
    light_code_t code;
    logic        code_stb;
    logic        blink;

    modport master (
        output brake,
        output turn,
        input  code,
        input  code_stb,
        input  blink
    );

    modport slave (
        input  brake,
        input  turn,
        output code,
        output code_stb,
        output blink
    );

endinterface

// File: rtl/db_filter.sv
// Two-flop synchroniser plus level debouncer for one switch.
// chg is high in the cycle whose closing edge updates dout.
module db_filter #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic chg
);

    localparam int W = $clog2(DB_CYCLES + 1);
    localparam logic [W-1:0] LIM = W'(DB_CYCLES - 1);

    logic         x_m;
    logic         x_q;
    logic [W-1:0] cnt;

    assign chg = (x_q != dout) && (cnt == LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_m  <= 1'b0;
            x_q  <= 1'b0;
            dout <= 1'b0;
            cnt  <= '0;
        end else begin
            x_m <= din;
            x_q <= x_m;
            if (x_q == dout) begin
                cnt <= '0;
            end else if (chg) begin
                dout <= x_q;
                cnt  <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/signal_encoder.sv
// Debounces brake/turn switches into the light code, with a
// change strobe and the turn-flash phase.
module signal_encoder
    import light_pkg::*;
#(
    parameter int DB_CYCLES  = 16,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    signal_encoder_if.slave  bus
);

    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [BW-1:0] BLIM = BW'(BLINK_HALF - 1);

    logic          brake_s;
    logic          turn_s;
    logic          brake_chg;
    logic          turn_chg;
    logic          stb;
    logic          blink;
    logic [BW-1:0] bcnt;

    db_filter #(.DB_CYCLES(DB_CYCLES)) u_brake (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.brake),
        .dout  (brake_s),
        .chg   (brake_chg)
    );

    db_filter #(.DB_CYCLES(DB_CYCLES)) u_turn (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.turn),
        .dout  (turn_s),
        .chg   (turn_chg)
    );

    // Blink phase restarts high on every turn_s rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb   <= 1'b0;
            blink <= 1'b0;
            bcnt  <= '0;
        end else begin
            stb <= brake_chg | turn_chg;
            if (turn_chg) begin
                blink <= ~turn_s;
                bcnt  <= '0;
            end else if (turn_s) begin
                if (bcnt == BLIM) begin
                    blink <= ~blink;
                    bcnt  <= '0;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end
        end
    end

    assign bus.code     = encode(turn_s, brake_s);
    assign bus.code_stb = stb;
    assign bus.blink    = blink;

endmodule
